// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
// Issuing end of the 64-bit-result ALU interface. Accepts one operation at a
// time from the datapath control, presents operands/opcode/modifiers to the
// ALU, restarts and waits for the multi-cycle divider on DIV, then hands the
// captured 64-bit result back. Strictly one operation outstanding.
//
// Ports
//   clk                      clock, all state on rising edge
//   rst                      asynchronous active-low reset
//   req_valid/req_ready      request handshake
//   req_op/req_a/req_b       opcode (0..12 legal) and operands
//   req_inv/req_inc          output_inverted / output_inc modifiers
//   alu_a/alu_b/alu_aluop    operands and opcode driven to the ALU
//   alu_inv/alu_inc          modifiers driven to the ALU
//   alu_rst                  one-cycle divider restart pulse (DIV only)
//   alu_done                 divider finished
//   alu_res_high/low         ALU result halves
//   rsp_valid/rsp_ready      response handshake
//   rsp_high/rsp_low         captured result
//   rsp_err                  DIV timeout or illegal opcode (result zero)
//   busy                     an operation is in flight
// ---------------------------------------------------------------------------
module alu_op_sequencer #(
  parameter int SETTLE_CYC  = 1,
  parameter int DIV_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        req_inv,
  input  logic        req_inc,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_aluop,
  output logic        alu_inv,
  output logic        alu_inc,
  output logic        alu_rst,
  input  logic        alu_done,
  input  logic [31:0] alu_res_high,
  input  logic [31:0] alu_res_low,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_high,
  output logic [31:0] rsp_low,
  output logic        rsp_err,
  output logic        busy
);

  localparam logic [3:0] OP_DIV       = 4'd3;
  localparam logic [3:0] OP_FIRST_BAD = 4'd13;
  localparam logic [7:0] SETTLE_LAST  = 8'(SETTLE_CYC - 1);
  localparam logic [7:0] DIV_LAST     = 8'(DIV_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    SETTLE,
    WAIT_DIV,
    RESP
  } stateT;

  stateT      state;
  logic [7:0] cnt;

  // All outputs are registered; req_ready comes up on the first edge after
  // reset release and is re-armed on the response handshake edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      req_ready <= 1'b0;
      busy      <= 1'b0;
      alu_a     <= 32'd0;
      alu_b     <= 32'd0;
      alu_aluop <= 4'd0;
      alu_inv   <= 1'b0;
      alu_inc   <= 1'b0;
      alu_rst   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_high  <= 32'd0;
      rsp_low   <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      // alu_rst is a single-cycle pulse covering the ISSUE cycle only.
      alu_rst <= 1'b0;
      case (state)
        // Accept: operands go straight to the ALU-facing registers and stay
        // there until the next acceptance.
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            alu_a     <= req_a;
            alu_b     <= req_b;
            alu_aluop <= req_op;
            alu_inv   <= req_inv;
            alu_inc   <= req_inc;
            alu_rst   <= (req_op == OP_DIV);
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        // Issue: route by opcode; illegal opcodes answer immediately.
        ISSUE: begin
          cnt <= 8'd0;
          if (alu_aluop >= OP_FIRST_BAD) begin
            rsp_high  <= 32'd0;
            rsp_low   <= 32'd0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (alu_aluop == OP_DIV) begin
            state <= WAIT_DIV;
          end else begin
            state <= SETTLE;
          end
        end
        // Settle: let the combinational ALU path resolve before capture.
        SETTLE: begin
          cnt <= cnt + 8'd1;
          if (cnt == SETTLE_LAST) begin
            rsp_high  <= alu_res_high;
            rsp_low   <= alu_res_low;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        // Divider wait: done is checked before timeout so a done arriving on
        // the last allowed cycle still returns a real result.
        WAIT_DIV: begin
          cnt <= cnt + 8'd1;
          if (alu_done) begin
            rsp_high  <= alu_res_high;
            rsp_low   <= alu_res_low;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (cnt == DIV_LAST) begin
            rsp_high  <= 32'd0;
            rsp_low   <= 32'd0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        // Response: hold everything until the consumer takes it.
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

  localparam int SETTLE_CYC  = 1;
  localparam int DIV_TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = 4'd0;
  logic [31:0] req_a = 32'd0;
  logic [31:0] req_b = 32'd0;
  logic        req_inv = 1'b0;
  logic        req_inc = 1'b0;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_aluop;
  logic        alu_inv, alu_inc, alu_rst;
  logic        alu_done;
  logic [31:0] alu_res_high, alu_res_low;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_high, rsp_low;
  logic        rsp_err;
  logic        busy;

  int passCnt  = 0;
  int totalCnt = 0;
  int cyc      = 0;
  int divDelay = 0;   // cycles from alu_rst to done; 0 = divider never finishes
  int divCnt;

  alu_op_sequencer #(.SETTLE_CYC(SETTLE_CYC), .DIV_TIMEOUT(DIV_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_inv(req_inv), .req_inc(req_inc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_aluop(alu_aluop),
    .alu_inv(alu_inv), .alu_inc(alu_inc), .alu_rst(alu_rst),
    .alu_done(alu_done), .alu_res_high(alu_res_high), .alu_res_low(alu_res_low),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_high(rsp_high), .rsp_low(rsp_low), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU: 64-bit result {high, low}, modifiers applied last.
  function automatic logic [63:0] aluFn(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic inv, input logic inc);
    logic [63:0] r;
    logic [31:0] t;
    int n;
    r = 64'd0;
    case (op)
      4'd0: r = {32'd0, a} + {32'd0, b};
      4'd1: r = {{32{a[31]}}, a} - {{32{b[31]}}, b};
      4'd2: r = {32'd0, a} * {32'd0, b};
      4'd3: r = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      4'd4: r = {32'd0, a & b};
      4'd5: r = {32'd0, a | b};
      4'd6: r = {32'd0, a ^ b};
      4'd7, 4'd8: begin
        n = 0;
        while (n < 32 && a[31-n] == (op == 4'd7)) n++;
        r = 64'(n);
      end
      4'd9:  r = {32'd0, a << b[4:0]};
      4'd10: r = {32'd0, a >> b[4:0]};
      4'd11: begin t = $unsigned($signed(a) >>> b[4:0]); r = {32'd0, t}; end
      4'd12: begin t = (a << b[4:0]) | (a >> (6'd32 - {1'b0, b[4:0]})); r = {32'd0, t}; end
      default: r = 64'd0;
    endcase
    if (inv) r = ~r;
    if (inc) r = r + 64'd1;
    return r;
  endfunction

  logic [63:0] aluRes;
  assign aluRes       = aluFn(alu_aluop, alu_a, alu_b, alu_inv, alu_inc);
  assign alu_res_high = aluRes[63:32];
  assign alu_res_low  = aluRes[31:0];

  // Divider timing model: done pulses divDelay cycles after the alu_rst cycle.
  always @(posedge clk or negedge rst) begin
    if (!rst) divCnt <= 0;
    else if (alu_rst) divCnt <= 1;
    else if (divCnt != 0 && divCnt < 1000) divCnt <= divCnt + 1;
  end
  assign alu_done = (divDelay != 0) && (divCnt == divDelay);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic endRun();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  endtask

  // Reference: what a request must produce, straight from the rules.
  task automatic predict(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic inv, input logic inc, input int d,
                         output logic [31:0] eh, output logic [31:0] el,
                         output logic ee, output int lat);
    logic [63:0] r;
    if (op >= 4'd13) begin
      eh = 0; el = 0; ee = 1'b1; lat = 2;
    end else if (op == 4'd3) begin
      if (d >= 1 && d <= DIV_TIMEOUT) begin
        r = aluFn(op, a, b, inv, inc); eh = r[63:32]; el = r[31:0]; ee = 1'b0; lat = d + 2;
      end else begin
        eh = 0; el = 0; ee = 1'b1; lat = DIV_TIMEOUT + 2;
      end
    end else begin
      r = aluFn(op, a, b, inv, inc); eh = r[63:32]; el = r[31:0]; ee = 1'b0; lat = 2 + SETTLE_CYC;
    end
  endtask

  // One full transaction, entered and left at a negedge with the DUT idle.
  task automatic runOp(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic inv, input logic inc,
                       input int d, input int hold, input logic [31:0] eh,
                       input logic [31:0] el, input logic ee, input int lat);
    int n, startCyc, rstSeen;
    logic readyBad, stable;
    logic [31:0] sh, sl, sa, sb;
    logic [3:0] sop;
    logic se, sinv, sinc;
    divDelay = d;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_inv = inv; req_inc = inc;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) begin
      check({tag, " accept"}, 0, 1);
      req_valid = 1'b0;
      endRun();
    end
    startCyc = cyc;
    @(negedge clk);
    // Keep a conflicting request pending; it must be ignored.
    req_op = ~op; req_a = ~a; req_b = ~b; req_inv = ~inv; req_inc = ~inc;
    check({tag, " alu_rst issue"}, alu_rst, op == 4'd3);
    check({tag, " alu_a"}, alu_a, a);
    check({tag, " alu_b"}, alu_b, b);
    check({tag, " alu_op/mod"}, {alu_aluop, alu_inv, alu_inc}, {op, inv, inc});
    rstSeen = int'(alu_rst);
    readyBad = 1'b0;
    n = 0;
    while (!rsp_valid && n < 300) begin
      if (req_ready) readyBad = 1'b1;
      @(negedge clk);
      rstSeen += int'(alu_rst);
      n++;
    end
    if (!rsp_valid) begin
      check({tag, " rsp_valid timeout"}, 0, 1);
      endRun();
    end
    check({tag, " latency"}, cyc - startCyc, lat);
    check({tag, " rsp_high"}, rsp_high, eh);
    check({tag, " rsp_low"}, rsp_low, el);
    check({tag, " rsp_err"}, rsp_err, ee);
    check({tag, " alu_rst cycles"}, rstSeen, (op == 4'd3) ? 1 : 0);
    check({tag, " req_ready while busy"}, readyBad, 0);
    sh = rsp_high; sl = rsp_low; se = rsp_err;
    sa = alu_a; sb = alu_b; sop = alu_aluop; sinv = alu_inv; sinc = alu_inc;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!rsp_valid || req_ready || rsp_high !== sh || rsp_low !== sl || rsp_err !== se ||
          alu_a !== sa || alu_b !== sb || alu_aluop !== sop || alu_inv !== sinv || alu_inc !== sinc)
        stable = 1'b0;
    end
    check({tag, " held stable"}, stable, 1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check({tag, " post rsp_valid"}, rsp_valid, 0);
    check({tag, " post busy"}, busy, 0);
    check({tag, " post req_ready"}, req_ready, 1);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        inv, inc;
    int          dly, hold;
    logic [31:0] expHigh, expLow;
    logic        expErr;
    int          expLat;
  } vecT;

  vecT vecs[14];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] op;
    logic [31:0] a, b, eh, el;
    logic inv, inc, ee;
    int d, lat;

    //          op     a             b             inv   inc   dly hold high          low           err   lat
    vecs[0]  = '{4'd0, 32'h5,        32'h3,        1'b0, 1'b0, 0,  0,   32'h0,        32'h8,        1'b0, 3};
    vecs[1]  = '{4'd1, 32'h3,        32'h5,        1'b1, 1'b1, 0,  1,   32'h0,        32'h2,        1'b0, 3};
    vecs[2]  = '{4'd3, 32'd100,      32'd7,        1'b0, 1'b0, 34, 0,   32'd2,        32'd14,       1'b0, 36};
    vecs[3]  = '{4'd3, 32'd100,      32'd7,        1'b0, 1'b0, 0,  0,   32'h0,        32'h0,        1'b1, 66};
    vecs[4]  = '{4'd3, 32'd100,      32'd7,        1'b0, 1'b0, 64, 0,   32'd2,        32'd14,       1'b0, 66};
    vecs[5]  = '{4'd3, 32'd100,      32'd7,        1'b0, 1'b0, 65, 2,   32'h0,        32'h0,        1'b1, 66};
    vecs[6]  = '{4'd13, 32'h1,       32'h2,        1'b0, 1'b0, 0,  0,   32'h0,        32'h0,        1'b1, 2};
    vecs[7]  = '{4'd15, 32'hFFFF,    32'h2,        1'b1, 1'b1, 0,  0,   32'h0,        32'h0,        1'b1, 2};
    vecs[8]  = '{4'd4, 32'hF0F01234, 32'h0FF0FFFF, 1'b0, 1'b0, 0,  10,  32'h0,        32'h00F01234, 1'b0, 3};
    vecs[9]  = '{4'd2, 32'h10000,    32'h10000,    1'b0, 1'b0, 0,  0,   32'h1,        32'h0,        1'b0, 3};
    vecs[10] = '{4'd6, 32'hFFFF0000, 32'h0F0F0F0F, 1'b0, 1'b0, 0,  0,   32'h0,        32'hF0F00F0F, 1'b0, 3};
    vecs[11] = '{4'd8, 32'h00010000, 32'h0,        1'b0, 1'b0, 0,  0,   32'h0,        32'd15,       1'b0, 3};
    vecs[12] = '{4'd11, 32'h80000000, 32'd4,       1'b0, 1'b0, 0,  0,   32'h0,        32'hF8000000, 1'b0, 3};
    vecs[13] = '{4'd0, 32'hFFFFFFFF, 32'h1,        1'b0, 1'b0, 0,  0,   32'h1,        32'h0,        1'b0, 3};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset req_ready", req_ready, 0);
    check("reset rsp_valid", rsp_valid, 0);
    check("reset busy", busy, 0);
    check("reset alu_rst", alu_rst, 0);
    check("reset outputs", {alu_a, alu_b, alu_aluop, rsp_high, rsp_low, rsp_err}, 0);
    rst = 1'b1;
    @(negedge clk);
    check("release req_ready", req_ready, 1);
    check("release busy", busy, 0);

    for (int i = 0; i < 14; i++)
      runOp($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].inv, vecs[i].inc,
            vecs[i].dly, vecs[i].hold, vecs[i].expHigh, vecs[i].expLow, vecs[i].expErr, vecs[i].expLat);

    // Reset in the middle of a divider wait
    divDelay = 0;
    req_valid = 1'b1; req_op = 4'd3; req_a = 32'd50; req_b = 32'd5; req_inv = 1'b0; req_inc = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("midrst busy before", busy, 1);
    #2 rst = 1'b0;
    #1;
    check("midrst req_ready", req_ready, 0);
    check("midrst busy", busy, 0);
    check("midrst rsp_valid", rsp_valid, 0);
    check("midrst alu_rst", alu_rst, 0);
    check("midrst outputs", {alu_a, alu_b, alu_aluop, rsp_high, rsp_low, rsp_err}, 0);
    repeat (3) @(negedge clk);
    check("midrst no response", rsp_valid, 0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst release ready", req_ready, 1);
    runOp("after reset", 4'd0, 32'd20, 32'd22, 1'b0, 1'b0, 0, 0, 32'h0, 32'd42, 1'b0, 3);

    // Randomised operations against the reference
    for (int i = 0; i < 40; i++) begin
      op  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) op = 4'd3;
      a   = $urandom;
      b   = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      inv = 1'($urandom_range(0, 1));
      inc = 1'($urandom_range(0, 1));
      d   = $urandom_range(0, 70);
      predict(op, a, b, inv, inc, d, eh, el, ee, lat);
      runOp($sformatf("rand%0d op%0d", i, op), op, a, b, inv, inc, d,
            $urandom_range(0, 3), eh, el, ee, lat);
    end

    endRun();
  end

endmodule
